decoder: RTL and testbench
==========================

// Module: decoder
// PURPOSE
//  Instruction decoder and micro-cycle sequencer for the 16-bit playground CPU.
//  Sits between the fetch unit and the datapath.
//  Latches one instruction word, steps it through FETCH/DECODE/EXEC/WB, and
//  emits register fields, an extended immediate and per-cycle control strobes.
// PARAMETERS
//  DATA_W  16  datapath width; imm_o is sign- or zero-extended to this width (>=16)
// PORTS
//  clk            in   1       single clock, rising edge
//  reset          in   1       asynchronous, active-high reset
//  instr_i        in   16      instruction word from fetch
//  instr_valid_i  in   1       instr_i valid; sampled only in FETCH
//  icycle_o       out  2       current micro-cycle: 0 FETCH, 1 DECODE, 2 EXEC, 3 WB
//  opcode_o       out  4       latched instr[15:12]
//  rd_o/rs1_o/rs2_o out 3 each instr[11:9] / [8:6] / [5:3]
//  imm_o          out  DATA_W  extended immediate, per format below
//  alu_op_o       out  3       ALU function
//  alu_src_imm_o  out  1       ALU operand B = imm_o
//  reg_we_o       out  1       register write strobe, WB cycle only
//  mem_re_o       out  1       memory read strobe, EXEC cycle only
//  mem_we_o       out  1       memory write strobe, EXEC cycle only
//  branch_o       out  1       conditional branch (BEQZ), EXEC cycle only
//  jump_o         out  1       unconditional jump, EXEC cycle only
//  halted_o       out  1       HALT executed; sticky until reset
//  illegal_o      out  1       undefined opcode; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async): icycle=FETCH, instruction register=0, all outputs 0.
//  - FETCH holds until instr_valid_i=1. On that edge instr_i is latched and the state
//    goes to DECODE. After that: DECODE->EXEC->WB->FETCH, one cycle each.
//  - Fields and control outputs are registered at the DECODE->EXEC edge.
//    They hold their values until the next DECODE.
//  - Strobes are qualified by state:
//      mem_re/mem_we/branch/jump = 1 only while icycle=EXEC
//      reg_we = 1 only while icycle=WB
//  - Opcode map:
//      0 NOP       no strobes
//      1-7 ADD,SUB,AND,OR,XOR,SHL,SHR  alu_op=opcode[2:0], reg_we
//      8 ADDI      imm=sext(instr[5:0]), alu_op=1, alu_src_imm, reg_we
//      9 LDI       imm=zext(instr[8:0]), alu_op=0 (pass B), alu_src_imm, reg_we
//      A LD        imm=sext(instr[5:0]), alu_op=1, alu_src_imm, mem_re, reg_we
//      B ST        imm=sext(instr[5:0]), alu_op=1, alu_src_imm, mem_we; data register=rd
//      C BEQZ      imm=sext(instr[8:0]), branch; test register=rd
//      D JMP       imm=sext(instr[11:0]), jump
//      E HALT      halted_o=1 at the DECODE->EXEC edge; the sequencer then stays in
//                  EXEC with no strobes until reset
//      F           reserved/undefined
//  - For formats without an immediate, imm_o=0.
//  - instr_valid_i outside FETCH is ignored.
//  - Reset asserted mid-instruction aborts it immediately; no strobe appears after
//    reset deasserts until a new instruction reaches EXEC.
// CONFIGURATION
//  DECODER_ILLEGAL_TRAP_EN defined:
//    - opcode F sets illegal_o=1 and halted_o=1 (sticky, same as HALT)
//    - all strobes stay 0
//  Not defined:
//    - opcode F decodes as NOP
//    - illegal_o tied 0
// STRUCTURE
//  - Package decoder_pkg holds:
//      opcode enum (OP_NOP..OP_RSVD)
//      icycle enum (CYC_FETCH/DECODE/EXEC/WB)
//      alu_op constants
//      field bit-position localparams
//  - One sub-module, decoder_ctl: a purely combinational opcode-to-control/immediate table.
//  - The top level holds the sequencer FSM, instruction register and output registers.
// TESTING
//  1. Reset and idle:
//     - reset=1 for 2 cycles, then instr_valid=0 for 10 cycles
//     - required: icycle stays 0 and every output stays 0
//  2. ADD (instr=16'h1298, valid 1 cycle)
//     - icycle sequence 0,1,2,3,0
//     - rd=1, rs1=2, rs2=3, alu_op=1
//     - reg_we=1 only in WB
//  3. LD (16'hA4BF)
//     - rd=2, rs1=2, imm=16'hFFFF, alu_src_imm=1
//     - mem_re=1 only in EXEC; reg_we=1 in WB
//  4. BEQZ / JMP
//     - 16'hC1FF gives imm=16'hFFFF and branch=1 in EXEC
//     - 16'hD800 gives imm=16'hF800 and jump=1 in EXEC
//  5. HALT (16'hE000)
//     - halted_o=1 and icycle stays 2 for 20 cycles with no strobes
//     - then reset clears halted_o
//  6. Opcode F (16'hF000), run with and without DECODER_ILLEGAL_TRAP_EN
//     - macro on: illegal_o=1 and halted_o=1
//     - macro off: NOP behaviour, illegal_o=0
//  7. Reset mid-instruction
//     - assert reset during EXEC of an ST
//     - required: mem_we drops asynchronously and icycle returns to 0

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the playground CPU instruction decoder.
package decoder_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LDI  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_BEQZ = 4'hC,
    OP_JMP  = 4'hD,
    OP_HALT = 4'hE,
    OP_RSVD = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    CYC_FETCH  = 2'd0,
    CYC_DECODE = 2'd1,
    CYC_EXEC   = 2'd2,
    CYC_WB     = 2'd3
  } icycle_e;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_HI  = 15;
  localparam int unsigned OPC_LO  = 12;
  localparam int unsigned RD_HI   = 11;
  localparam int unsigned RD_LO   = 9;
  localparam int unsigned RS1_HI  = 8;
  localparam int unsigned RS1_LO  = 6;
  localparam int unsigned RS2_HI  = 5;
  localparam int unsigned RS2_LO  = 3;

  // Decoded control word for one instruction, before state qualification.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       branch;
    logic       jump;
    logic       halt;
    logic       illegal;
  } ctl_t;

endpackage

// File: rtl/decoder_ctl.sv
// Combinational opcode-to-control and immediate-extension table.
// With DECODER_ILLEGAL_TRAP_EN defined, opcode F traps; otherwise it is a NOP.
module decoder_ctl
  import decoder_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  output ctl_t               ctl,
  output logic [DATA_W-1:0]  imm
);

  opcode_e           opc;
  logic [DATA_W-1:0] imm_s6;
  logic [DATA_W-1:0] imm_z9;
  logic [DATA_W-1:0] imm_s9;
  logic [DATA_W-1:0] imm_s12;

  assign opc     = opcode_e'(instr[OPC_HI:OPC_LO]);
  assign imm_s6  = {{(DATA_W-6){instr[5]}}, instr[5:0]};
  assign imm_z9  = DATA_W'(instr[8:0]);
  assign imm_s9  = {{(DATA_W-9){instr[8]}}, instr[8:0]};
  assign imm_s12 = {{(DATA_W-12){instr[11]}}, instr[11:0]};

  always_comb begin
    ctl = '0;
    imm = '0;
    case (opc)
      OP_NOP: begin
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        ctl.alu_op = instr[OPC_LO+2:OPC_LO];
        ctl.reg_we = 1'b1;
      end
      OP_ADDI: begin
        imm             = imm_s6;
        ctl.alu_op      = ALU_ADD;
        ctl.alu_src_imm = 1'b1;
        ctl.reg_we      = 1'b1;
      end
      OP_LDI: begin
        imm             = imm_z9;
        ctl.alu_op      = ALU_PASS;
        ctl.alu_src_imm = 1'b1;
        ctl.reg_we      = 1'b1;
      end
      OP_LD: begin
        imm             = imm_s6;
        ctl.alu_op      = ALU_ADD;
        ctl.alu_src_imm = 1'b1;
        ctl.mem_re      = 1'b1;
        ctl.reg_we      = 1'b1;
      end
      OP_ST: begin
        imm             = imm_s6;
        ctl.alu_op      = ALU_ADD;
        ctl.alu_src_imm = 1'b1;
        ctl.mem_we      = 1'b1;
      end
      OP_BEQZ: begin
        imm        = imm_s9;
        ctl.branch = 1'b1;
      end
      OP_JMP: begin
        imm      = imm_s12;
        ctl.jump = 1'b1;
      end
      OP_HALT: begin
        ctl.halt = 1'b1;
      end
`ifdef DECODER_ILLEGAL_TRAP_EN
      OP_RSVD: begin
        ctl.illegal = 1'b1;
        ctl.halt    = 1'b1;
      end
`else
      OP_RSVD: begin
      end
`endif
    endcase
  end

endmodule

// File: rtl/decoder.sv
// Instruction register, FETCH/DECODE/EXEC/WB sequencer and registered decode outputs.
// Opcode F trap behaviour is selected by DECODER_ILLEGAL_TRAP_EN (see decoder_ctl).
module decoder
  import decoder_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instr_i,
  input  logic                instr_valid_i,
  output logic [1:0]          icycle_o,
  output logic [3:0]          opcode_o,
  output logic [2:0]          rd_o,
  output logic [2:0]          rs1_o,
  output logic [2:0]          rs2_o,
  output logic [DATA_W-1:0]   imm_o,
  output logic [2:0]          alu_op_o,
  output logic                alu_src_imm_o,
  output logic                reg_we_o,
  output logic                mem_re_o,
  output logic                mem_we_o,
  output logic                branch_o,
  output logic                jump_o,
  output logic                halted_o,
  output logic                illegal_o
);

  icycle_e             cyc;
  logic [INSTR_W-1:0]  ir;
  logic                we_pend;
  ctl_t                ctl_d;
  logic [DATA_W-1:0]   imm_d;

  decoder_ctl #(.DATA_W(DATA_W)) u_ctl (
    .instr (ir),
    .ctl   (ctl_d),
    .imm   (imm_d)
  );

  assign icycle_o = 2'(cyc);

  // Strobes are set on entry to their cycle and cleared on exit, so they stay registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc           <= CYC_FETCH;
      ir            <= '0;
      we_pend       <= 1'b0;
      opcode_o      <= '0;
      rd_o          <= '0;
      rs1_o         <= '0;
      rs2_o         <= '0;
      imm_o         <= '0;
      alu_op_o      <= '0;
      alu_src_imm_o <= 1'b0;
      reg_we_o      <= 1'b0;
      mem_re_o      <= 1'b0;
      mem_we_o      <= 1'b0;
      branch_o      <= 1'b0;
      jump_o        <= 1'b0;
      halted_o      <= 1'b0;
      illegal_o     <= 1'b0;
    end else begin
      case (cyc)
        CYC_FETCH: begin
          if (instr_valid_i) begin
            ir  <= instr_i;
            cyc <= CYC_DECODE;
          end
        end
        CYC_DECODE: begin
          opcode_o      <= ir[OPC_HI:OPC_LO];
          rd_o          <= ir[RD_HI:RD_LO];
          rs1_o         <= ir[RS1_HI:RS1_LO];
          rs2_o         <= ir[RS2_HI:RS2_LO];
          imm_o         <= imm_d;
          alu_op_o      <= ctl_d.alu_op;
          alu_src_imm_o <= ctl_d.alu_src_imm;
          we_pend       <= ctl_d.reg_we;
          mem_re_o      <= ctl_d.mem_re;
          mem_we_o      <= ctl_d.mem_we;
          branch_o      <= ctl_d.branch;
          jump_o        <= ctl_d.jump;
          halted_o      <= ctl_d.halt;
          illegal_o     <= ctl_d.illegal;
          cyc           <= CYC_EXEC;
        end
        CYC_EXEC: begin
          // A halted core parks here with no strobes until reset.
          if (!halted_o) begin
            mem_re_o <= 1'b0;
            mem_we_o <= 1'b0;
            branch_o <= 1'b0;
            jump_o   <= 1'b0;
            reg_we_o <= we_pend;
            cyc      <= CYC_WB;
          end
        end
        CYC_WB: begin
          reg_we_o <= 1'b0;
          cyc      <= CYC_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for the decoder sequencer and decode table.
module tb_decoder;

  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       instr;
  logic              instr_valid;
  logic [1:0]        icycle;
  logic [3:0]        opcode;
  logic [2:0]        rd, rs1, rs2;
  logic [DATA_W-1:0] imm;
  logic [2:0]        alu_op;
  logic              alu_src_imm, reg_we, mem_re, mem_we, branch, jump, halted, illegal;

  logic [4:0]        strb;
  logic [39:0]       all_out;

  int checks   = 0;
  int failures = 0;

  decoder #(.DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_i       (instr),
    .instr_valid_i (instr_valid),
    .icycle_o      (icycle),
    .opcode_o      (opcode),
    .rd_o          (rd),
    .rs1_o         (rs1),
    .rs2_o         (rs2),
    .imm_o         (imm),
    .alu_op_o      (alu_op),
    .alu_src_imm_o (alu_src_imm),
    .reg_we_o      (reg_we),
    .mem_re_o      (mem_re),
    .mem_we_o      (mem_we),
    .branch_o      (branch),
    .jump_o        (jump),
    .halted_o      (halted),
    .illegal_o     (illegal)
  );

  always #5 clk = ~clk;

  // strobe order: {reg_we, mem_re, mem_we, branch, jump}
  assign strb    = {reg_we, mem_re, mem_we, branch, jump};
  assign all_out = {opcode, rd, rs1, rs2, imm, alu_op, alu_src_imm, strb, halted, illegal};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue w from FETCH and advance to EXEC; a bait word is offered during DECODE.
  task automatic to_exec(input string tag, input logic [15:0] w, input logic [4:0] exec_strb);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr       = 16'hE000;
    instr_valid = 1'b1;
    chk({tag, "_dec_cyc"}, 64'(icycle), 64'd1);
    chk({tag, "_dec_strb"}, 64'(strb), 64'd0);
    tick();
    instr       = 16'h0000;
    instr_valid = 1'b0;
    chk({tag, "_exec_cyc"}, 64'(icycle), 64'd2);
    chk({tag, "_exec_strb"}, 64'(strb), 64'(exec_strb));
    chk({tag, "_opcode"}, 64'(opcode), 64'(w[15:12]));
  endtask

  task automatic finish_instr(input string tag, input logic [4:0] wb_strb);
    tick();
    chk({tag, "_wb_cyc"}, 64'(icycle), 64'd3);
    chk({tag, "_wb_strb"}, 64'(strb), 64'(wb_strb));
    tick();
    chk({tag, "_fetch_cyc"}, 64'(icycle), 64'd0);
    chk({tag, "_fetch_strb"}, 64'(strb), 64'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    chk("rst_async_cyc", 64'(icycle), 64'd0);
    chk("rst_async_out", 64'(all_out), 64'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    instr       = 16'h0000;
    instr_valid = 1'b0;

    // Reset and idle
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_cyc", 64'(icycle), 64'd0);
      chk("rst_out", 64'(all_out), 64'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_cyc", 64'(icycle), 64'd0);
      chk("idle_out", 64'(all_out), 64'd0);
    end

    // ADD r1, r2, r3
    to_exec("add", 16'h1298, 5'b00000);
    chk("add_regs", 64'({rd, rs1, rs2}), 64'({3'd1, 3'd2, 3'd3}));
    chk("add_alu", 64'({alu_op, alu_src_imm}), 64'({3'd1, 1'b0}));
    chk("add_imm", 64'(imm), 64'h0);
    finish_instr("add", 5'b10000);
    chk("add_hold_rd", 64'(rd), 64'd1);

    // LD
    to_exec("ld", 16'hA4BF, 5'b01000);
    chk("ld_regs", 64'({rd, rs1}), 64'({3'd2, 3'd2}));
    chk("ld_imm", 64'(imm), 64'hFFFF);
    chk("ld_alu", 64'({alu_op, alu_src_imm}), 64'({3'd1, 1'b1}));
    finish_instr("ld", 5'b10000);

    // ADDI r5, r1, 5
    to_exec("addi", 16'h8A45, 5'b00000);
    chk("addi_regs", 64'({rd, rs1}), 64'({3'd5, 3'd1}));
    chk("addi_imm", 64'(imm), 64'h0005);
    chk("addi_alu", 64'({alu_op, alu_src_imm}), 64'({3'd1, 1'b1}));
    finish_instr("addi", 5'b10000);

    // LDI r1, 0x1FF (zero-extended)
    to_exec("ldi", 16'h93FF, 5'b00000);
    chk("ldi_rd", 64'(rd), 64'd1);
    chk("ldi_imm", 64'(imm), 64'h01FF);
    chk("ldi_alu", 64'({alu_op, alu_src_imm}), 64'({3'd0, 1'b1}));
    finish_instr("ldi", 5'b10000);

    // BEQZ and JMP
    to_exec("beqz", 16'hC1FF, 5'b00010);
    chk("beqz_imm", 64'(imm), 64'hFFFF);
    finish_instr("beqz", 5'b00000);
    to_exec("jmp", 16'hD800, 5'b00001);
    chk("jmp_imm", 64'(imm), 64'hF800);
    finish_instr("jmp", 5'b00000);

    // HALT parks in EXEC and ignores new instructions
    to_exec("halt", 16'hE000, 5'b00000);
    chk("halt_flag", 64'({halted, illegal}), 64'({1'b1, 1'b0}));
    instr       = 16'h1298;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold", 64'({icycle, strb, halted}), 64'({2'd2, 5'd0, 1'b1}));
    end
    instr_valid = 1'b0;
    pulse_reset();
    chk("halt_cleared", 64'(halted), 64'd0);

    // Reserved opcode F
    to_exec("rsvd", 16'hF000, 5'b00000);
`ifdef DECODER_ILLEGAL_TRAP_EN
    chk("rsvd_trap", 64'({illegal, halted}), 64'({1'b1, 1'b1}));
    tick();
    chk("rsvd_park", 64'({icycle, strb}), 64'({2'd2, 5'd0}));
    pulse_reset();
`else
    chk("rsvd_nop", 64'({illegal, halted}), 64'({1'b0, 1'b0}));
    chk("rsvd_alu", 64'({alu_op, alu_src_imm, imm}), 64'h0);
    finish_instr("rsvd", 5'b00000);
`endif

    // Reset during EXEC of ST
    to_exec("st", 16'hB6C2, 5'b00100);
    chk("st_fields", 64'({rd, rs1, imm}), 64'({3'd3, 3'd3, 16'h0002}));
    reset = 1'b1;
    #1;
    chk("st_rst_memwe", 64'(mem_we), 64'd0);
    chk("st_rst_cyc", 64'(icycle), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst", 64'({icycle, strb}), 64'({2'd0, 5'd0}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
